// File: rtl/pcie_tlp_encoder_if.sv
// Command, payload and s_axis_rq bundle for the RQ TLP encoder.
// master = encoder side, slave = command logic / PCIe core side.
interface pcie_tlp_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_write;
  logic [63:0] req_addr;
  logic [10:0] req_dword_count;
  logic [7:0]  req_tag;

  logic [63:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;

  logic [63:0] s_axis_rq_tdata;
  logic [1:0]  s_axis_rq_tkeep;
  logic        s_axis_rq_tlast;
  logic        s_axis_rq_tready;
  logic [59:0] s_axis_rq_tuser;
  logic        s_axis_rq_tvalid;

  modport master (
    input  req_valid,
    input  req_is_write,
    input  req_addr,
    input  req_dword_count,
    input  req_tag,
    input  wr_data,
    input  wr_valid,
    input  s_axis_rq_tready,
    output req_ready,
    output wr_ready,
    output s_axis_rq_tdata,
    output s_axis_rq_tkeep,
    output s_axis_rq_tlast,
    output s_axis_rq_tuser,
    output s_axis_rq_tvalid
  );

  modport slave (
    output req_valid,
    output req_is_write,
    output req_addr,
    output req_dword_count,
    output req_tag,
    output wr_data,
    output wr_valid,
    output s_axis_rq_tready,
    input  req_ready,
    input  wr_ready,
    input  s_axis_rq_tdata,
    input  s_axis_rq_tkeep,
    input  s_axis_rq_tlast,
    input  s_axis_rq_tuser,
    input  s_axis_rq_tvalid
  );
endinterface

// File: rtl/pcie_tlp_encoder.sv
// Requester-request TLP builder: MemRd/MemWr command to a 2-beat
// RQ descriptor plus payload on a registered 64-bit s_axis_rq stage.
module pcie_tlp_encoder #(
  parameter int          AXIS_DATA_WIDTH = 64,
  parameter int          MAX_DW          = 256,
  parameter logic [15:0] REQUESTER_ID    = 16'h0000
) (
  input  logic               user_clk,
  input  logic               user_reset,
  input  logic               user_lnk_up,
  pcie_tlp_encoder_if.master rq,
  output logic               req_done,
  output logic               req_err,
  output logic               req_abort
);

  localparam int BEAT_DW = AXIS_DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    IDLE,
    DESC0,
    DESC1,
    DATA
  } state_t;

  state_t state;
  state_t state_n;

  logic        is_wr_q;
  logic [10:0] cnt_q;
  logic [7:0]  tag_q;
  logic [10:0] dw_left;

  logic        tvalid_q;
  logic [63:0] tdata_q;
  logic [1:0]  tkeep_q;
  logic        tlast_q;
  logic [59:0] tuser_q;

  logic        done_q;
  logic        err_q;
  logic        abort_q;

  logic        req_ready_c;
  logic        wr_ready_c;
  logic        accept;
  logic        bad_len;
  logic        load_en;
  logic        last_hs;
  logic        wr_hs;
  logic        final_beat;

  logic        ld_desc0;
  logic        ld_desc1;
  logic        ld_data;
  logic        clr_valid;
  logic        abort_set;

  logic [31:0] dw2;
  logic [31:0] dw3;
  logic [3:0]  req_type;

  function automatic logic [59:0] be_of(
    input logic [10:0] cnt
  );
    logic [3:0] last_be;
    last_be = (cnt == 11'd1) ? 4'h0 : 4'hF;
    return {52'h0, last_be, 4'hF};
  endfunction

  assign load_en = !tvalid_q || rq.s_axis_rq_tready;
  assign last_hs = tvalid_q && rq.s_axis_rq_tready
                && tlast_q;

  assign req_ready_c = (state == IDLE)
                    && user_lnk_up
                    && !user_reset;
  assign accept = rq.req_valid && req_ready_c;

  assign bad_len = (rq.req_dword_count == 11'd0)
                || (rq.req_dword_count > 11'(MAX_DW));

  // Link-down gating keeps a dying TLP from eating payload.
  assign wr_ready_c = (state == DATA) && load_en
                   && (dw_left != 11'd0)
                   && user_lnk_up;
  assign wr_hs = wr_ready_c && rq.wr_valid;

  assign final_beat = dw_left <= 11'(BEAT_DW);

  assign req_type = is_wr_q ? 4'b0001 : 4'b0000;
  assign dw2 = {REQUESTER_ID, 1'b0, req_type, cnt_q};
  assign dw3 = {8'h00, 16'h0000, tag_q};

  // State register.
  always_ff @(posedge user_clk) begin
    if (user_reset) state <= IDLE;
    else            state <= state_n;
  end

  // Next state and beat-load strobes; link-down overrides all.
  always_comb begin
    state_n   = state;
    ld_desc0  = 1'b0;
    ld_desc1  = 1'b0;
    ld_data   = 1'b0;
    clr_valid = 1'b0;
    abort_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && !bad_len) begin
          ld_desc0 = 1'b1;
          state_n  = DESC0;
        end
      end
      DESC0: begin
        if (rq.s_axis_rq_tready) begin
          ld_desc1 = 1'b1;
          state_n  = DESC1;
        end
      end
      DESC1: begin
        if (rq.s_axis_rq_tready) begin
          clr_valid = 1'b1;
          state_n   = is_wr_q ? DATA : IDLE;
        end
      end
      DATA: begin
        if (wr_hs)        ld_data   = 1'b1;
        else if (load_en) clr_valid = 1'b1;
        if (last_hs)      state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !user_lnk_up && !last_hs) begin
      state_n   = IDLE;
      ld_desc1  = 1'b0;
      ld_data   = 1'b0;
      clr_valid = 1'b1;
      abort_set = 1'b1;
    end
  end

  // Command latch, output stage and status pulses.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      is_wr_q  <= 1'b0;
      cnt_q    <= '0;
      tag_q    <= '0;
      dw_left  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      done_q  <= last_hs;
      err_q   <= accept && bad_len;
      abort_q <= abort_set;
      if (accept) begin
        is_wr_q <= rq.req_is_write;
        cnt_q   <= rq.req_dword_count;
        tag_q   <= rq.req_tag;
      end
      if (ld_desc0) begin
        tvalid_q <= 1'b1;
        tdata_q  <= {rq.req_addr[63:2], 2'b00};
        tkeep_q  <= 2'b11;
        tlast_q  <= 1'b0;
        tuser_q  <= be_of(rq.req_dword_count);
        dw_left  <= rq.req_dword_count;
      end else if (ld_desc1) begin
        tvalid_q <= 1'b1;
        tdata_q  <= {dw3, dw2};
        tkeep_q  <= 2'b11;
        tlast_q  <= !is_wr_q;
      end else if (ld_data) begin
        tvalid_q <= 1'b1;
        tlast_q  <= final_beat;
        if (dw_left == 11'd1) begin
          tdata_q <= {32'h0, rq.wr_data[31:0]};
          tkeep_q <= 2'b01;
          dw_left <= '0;
        end else begin
          tdata_q <= rq.wr_data;
          tkeep_q <= 2'b11;
          dw_left <= dw_left - 11'(BEAT_DW);
        end
      end else if (clr_valid) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign rq.req_ready        = req_ready_c;
  assign rq.wr_ready         = wr_ready_c;
  assign rq.s_axis_rq_tvalid = tvalid_q;
  assign rq.s_axis_rq_tdata  = tdata_q;
  assign rq.s_axis_rq_tkeep  = tkeep_q;
  assign rq.s_axis_rq_tlast  = tlast_q;
  assign rq.s_axis_rq_tuser  = tuser_q;

  assign req_done  = done_q;
  assign req_err   = err_q;
  assign req_abort = abort_q;

endmodule
